// File: rtl/disp_scan_sched.sv
// disp_scan_sched: scan scheduler for a 4-digit multiplexed seven-segment display.
// Drives one shared decoder code and active-low anodes from a double-buffered frame.
// New frames are promoted from the pending buffer only in IDLE or on a frame boundary.
// Optional feature macro: DISP_BLANK_EN adds an all-off gap of BLANK_CYCLES after each digit.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | scanning stopped, anodes off, idx=0, pending promoted freely
// S_LIGHT | digit idx lit for DIGIT_CYCLES cycles
// S_BLANK | all anodes off for BLANK_CYCLES cycles (DISP_BLANK_EN only)
module disp_scan_sched #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  output logic [3:0]  code,
  output logic [3:0]  anodes,
  output logic        frame_done
);

  localparam int MAXC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DIG_LOAD = CW'(DIGIT_CYCLES - 1);
`ifdef DISP_BLANK_EN
  localparam logic [CW-1:0] BLK_LOAD = CW'(BLANK_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LIGHT = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] cnt;
  logic [15:0]   active;
  logic [15:0]   pending;
  logic          pend_v;

  logic          accept;
  logic          tc;
  logic          last_digit;
  logic          boundary;
  logic          promote;
  logic [15:0]   act_nxt;
  logic [1:0]    idx_inc;
  logic [3:0]    adv_anodes;
  logic [3:0]    adv_code;

  assign wr_ready = ~pend_v;

  // Handshake, terminal count, boundary detection and next-digit values.
  always_comb begin
    accept     = wr_valid & ~pend_v;
    tc         = (cnt == '0);
    last_digit = (idx == 2'd3);
`ifdef DISP_BLANK_EN
    boundary   = enable & (state == S_BLANK) & tc & last_digit;
`else
    boundary   = enable & (state == S_LIGHT) & tc & last_digit;
`endif
    promote    = pend_v & ((state == S_IDLE) | boundary);
    // The digit shown right after a swap must come from the newly promoted frame.
    act_nxt    = promote ? pending : active;
    idx_inc    = idx + 2'd1;
    adv_anodes = ~(4'b0001 << idx_inc);
    adv_code   = act_nxt[{idx_inc, 2'b00} +: 4];
  end

  // Frame buffers, scan sequencer and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      cnt        <= '0;
      active     <= 16'h0000;
      pending    <= 16'h0000;
      pend_v     <= 1'b0;
      anodes     <= 4'b1111;
      code       <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (promote) begin
        active <= pending;
        pend_v <= 1'b0;
      end
      if (accept) begin
        pending <= wr_data;
        pend_v  <= 1'b1;
      end
      if (!enable) begin
        state  <= S_IDLE;
        idx    <= 2'd0;
        anodes <= 4'b1111;
      end else begin
        case (state)
          S_IDLE: begin
            state  <= S_LIGHT;
            idx    <= 2'd0;
            cnt    <= DIG_LOAD;
            anodes <= 4'b1110;
            code   <= act_nxt[3:0];
          end
          S_LIGHT: begin
            if (tc) begin
`ifdef DISP_BLANK_EN
              state  <= S_BLANK;
              cnt    <= BLK_LOAD;
              anodes <= 4'b1111;
`else
              idx        <= idx_inc;
              cnt        <= DIG_LOAD;
              anodes     <= adv_anodes;
              code       <= adv_code;
              frame_done <= last_digit;
`endif
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
`ifdef DISP_BLANK_EN
          S_BLANK: begin
            if (tc) begin
              state      <= S_LIGHT;
              idx        <= idx_inc;
              cnt        <= DIG_LOAD;
              anodes     <= adv_anodes;
              code       <= adv_code;
              frame_done <= last_digit;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
`endif
          default: begin
            state  <= S_IDLE;
            idx    <= 2'd0;
            anodes <= 4'b1111;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_disp_scan_sched.sv
// Testbench for disp_scan_sched with DIGIT_CYCLES=4, BLANK_CYCLES=2.
// Follows DISP_BLANK_EN if it is defined for the build.
module tb_disp_scan_sched;

  localparam int D = 4;
  localparam int B = 2;
`ifdef DISP_BLANK_EN
  localparam int P = D + B;
`else
  localparam int P = D;
`endif
  localparam int FP = 4 * P;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  code;
  logic [3:0]  anodes;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  disp_scan_sched #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .code      (code),
    .anodes    (anodes),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: scan position counted in cycles since scanning started.
  bit          m_scan;
  int          m_p;
  logic [15:0] m_active;
  logic [15:0] m_pending;
  bit          m_pend_v;
  logic [3:0]  m_an;
  logic [3:0]  m_code;
  bit          m_fd;

  task automatic model_reset();
    m_scan = 0; m_p = 0; m_active = 16'h0; m_pending = 16'h0; m_pend_v = 0;
    m_an = 4'hF; m_code = 4'h0; m_fd = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input logic [15:0] d);
    bit acc, prom, bnd;
    int q, dg, r;
    logic [3:0] one;
    one = 4'b0001;
    acc = v && !m_pend_v;
    prom = 0;
    m_fd = 0;
    if (!en) begin
      prom = m_pend_v && !m_scan;
      m_scan = 0;
    end else if (!m_scan) begin
      prom = m_pend_v;
      m_scan = 1;
      m_p = 0;
    end else begin
      bnd = ((m_p % FP) == FP - 1);
      m_p++;
      prom = bnd && m_pend_v;
      m_fd = bnd;
    end
    if (prom) begin
      m_active = m_pending;
      m_pend_v = 0;
    end
    if (m_scan) begin
      q = m_p % FP; dg = q / P; r = q % P;
      if (r < D) begin
        m_an = ~(one << dg);
        m_code = m_active[dg*4 +: 4];
      end else begin
        m_an = 4'hF;
      end
    end else begin
      m_an = 4'hF;
    end
    if (acc) begin
      m_pending = d;
      m_pend_v = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timeout waiting for event, got none expected one", nm);
  endtask

  task automatic check_model();
    chk("anodes", {12'h0, anodes}, {12'h0, m_an});
    chk("code", {12'h0, code}, {12'h0, m_code});
    chk("frame_done", {15'h0, frame_done}, {15'h0, m_fd});
    chk("wr_ready", {15'h0, wr_ready}, {15'h0, !m_pend_v});
  endtask

  task automatic cyc(input bit en, input bit v, input logic [15:0] d);
    enable = en; wr_valid = v; wr_data = d;
    @(posedge clk);
    model_step(en, v, d);
    @(negedge clk);
    check_model();
  endtask

  task automatic run_to_fd(input bit v, input logic [15:0] d, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 4 * FP; i++) begin
      cyc(1, v, d);
      if (m_fd) begin ok = 1; break; end
    end
    if (!ok) timeout(nm);
  endtask

  typedef struct {
    bit          en;
    bit          v;
    logic [15:0] d;
    logic [3:0]  an;
    logic [3:0]  code;
    bit          fd;
    bit          rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit en, bit v, logic [15:0] d, logic [3:0] an,
                              logic [3:0] cd, bit fd, bit rdy);
    vec_t x;
    x.en = en; x.v = v; x.d = d; x.an = an; x.code = cd; x.fd = fd; x.rdy = rdy;
    return x;
  endfunction

  initial begin
    logic [3:0] one;
    int fd_cnt;
    bit ok;
    one = 4'b0001;
    model_reset();
    rst_n = 1'b0; enable = 0; wr_valid = 0; wr_data = 16'h0;

    // Expected sequence for an IDLE load of 16'h4321 followed by one full frame.
    tbl.push_back(mk(0, 1, 16'h4321, 4'hF, 4'h0, 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 4'hF, 4'h0, 0, 1));
    for (int dg = 0; dg < 4; dg++)
      for (int r = 0; r < P; r++)
        tbl.push_back(mk(1, 0, 16'h0, (r < D) ? ~(one << dg) : 4'hF, 4'(dg + 1), 0, 1));
    tbl.push_back(mk(1, 0, 16'h0, 4'b1110, 4'h1, 1, 1));

    repeat (2) @(negedge clk);
    chk("rst_anodes", {12'h0, anodes}, 16'h000F);
    chk("rst_code", {12'h0, code}, 16'h0000);
    chk("rst_ready", {15'h0, wr_ready}, 16'h0001);
    rst_n = 1'b1;
    repeat (3) cyc(0, 0, 16'h0);

    // Table-driven IDLE load and first frame.
    foreach (tbl[i]) begin
      enable = tbl[i].en; wr_valid = tbl[i].v; wr_data = tbl[i].d;
      @(posedge clk);
      model_step(tbl[i].en, tbl[i].v, tbl[i].d);
      @(negedge clk);
      chk($sformatf("tbl%0d_anodes", i), {12'h0, anodes}, {12'h0, tbl[i].an});
      chk($sformatf("tbl%0d_code", i), {12'h0, code}, {12'h0, tbl[i].code});
      chk($sformatf("tbl%0d_fd", i), {15'h0, frame_done}, {15'h0, tbl[i].fd});
      chk($sformatf("tbl%0d_ready", i), {15'h0, wr_ready}, {15'h0, tbl[i].rdy});
    end

    // Tear-free swap: write mid-frame, old frame completes, new one follows.
    repeat (5) cyc(1, 0, 16'h0);
    cyc(1, 1, 16'h8765);
    chk("swap_ready_low", {15'h0, wr_ready}, 16'h0000);
    run_to_fd(0, 16'h0, "swap_boundary");
    chk("swap_new_code", {12'h0, code}, 16'h0005);
    chk("swap_ready_high", {15'h0, wr_ready}, 16'h0001);
    fd_cnt = 0;
    for (int i = 0; i < FP; i++) begin
      cyc(1, 0, 16'h0);
      if (frame_done) fd_cnt++;
    end
    chk("swap_fd_once", 16'(fd_cnt), 16'h0001);

    // Back-pressure: AAAA held while a frame is pending.
    cyc(1, 1, 16'h1234);
    run_to_fd(1, 16'hAAAA, "bp_boundary");
    chk("bp_promoted", {12'h0, code}, 16'h0004);
    chk("bp_ready_at_bnd", {15'h0, wr_ready}, 16'h0001);
    cyc(1, 1, 16'hAAAA);
    chk("bp_accept", {15'h0, wr_ready}, 16'h0000);
    run_to_fd(0, 16'h0, "bp_second");
    chk("bp_shown", {12'h0, code}, 16'h000A);

    // Boundary collision: write lands on the boundary cycle itself.
    ok = 0;
    for (int i = 0; i < 2 * FP; i++) begin
      if ((m_p % FP) == FP - 1) begin ok = 1; break; end
      cyc(1, 0, 16'h0);
    end
    if (!ok) timeout("coll_find");
    cyc(1, 1, 16'h9999);
    chk("coll_fd", {15'h0, frame_done}, 16'h0001);
    chk("coll_old", {12'h0, code}, 16'h000A);
    chk("coll_pending", {15'h0, wr_ready}, 16'h0000);
    run_to_fd(0, 16'h0, "coll_next");
    chk("coll_new", {12'h0, code}, 16'h0009);

    // Abort during digit 2, then restart from digit 0.
    ok = 0;
    for (int i = 0; i < 2 * FP; i++) begin
      cyc(1, 0, 16'h0);
      if (m_an == 4'b1011) begin ok = 1; break; end
    end
    if (!ok) timeout("abort_find");
    cyc(0, 0, 16'h0);
    chk("abort_off", {12'h0, anodes}, 16'h000F);
    chk("abort_no_fd", {15'h0, frame_done}, 16'h0000);
    cyc(0, 0, 16'h0);
    cyc(1, 0, 16'h0);
    chk("abort_restart_an", {12'h0, anodes}, 16'h000E);
    chk("abort_restart_code", {12'h0, code}, 16'h0009);

    // Asynchronous reset mid-frame with a frame pending.
    repeat (3) cyc(1, 0, 16'h0);
    cyc(1, 1, 16'h5555);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_anodes", {12'h0, anodes}, 16'h000F);
    chk("mid_rst_code", {12'h0, code}, 16'h0000);
    chk("mid_rst_fd", {15'h0, frame_done}, 16'h0000);
    chk("mid_rst_ready", {15'h0, wr_ready}, 16'h0001);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 16'h0);
    cyc(1, 0, 16'h0);
    chk("post_rst_code", {12'h0, code}, 16'h0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 39) != 0, $urandom_range(0, 5) == 0, 16'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_scan_sched.md
# disp_scan_sched

Scan scheduler for the 4-digit multiplexed seven-segment display. It time-shares the single `seven_segment_controller` decoder across the four digits by driving its 4-bit `data` input and the active-low digit anodes. The block holds a double-buffered 4-digit frame that host logic loads through a valid/ready handshake. New frames are swapped in only at frame boundaries, so a displayed frame never mixes digits from two different loads.

## Interface
Parameters:
- `DIGIT_CYCLES`, default 50000: clock cycles each digit is lit. Must be ≥1.
- `BLANK_CYCLES`, default 500: clock cycles all anodes are off between digits. Must be ≥1. Used only with `DISP_BLANK_EN`.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: scanning enable, sampled every cycle.
- `wr_valid` input 1: host presents a frame.
- `wr_ready` output 1: the pending buffer is empty, so a write can be accepted.
- `wr_data` input 16: frame contents. Bits [3:0] are digit 0 (anode bit 0, rightmost) and bits [15:12] are digit 3.
- `code` output 4: digit code, connected to the decoder `data` input.
- `anodes` output 4: active-low digit enables. At most one bit is low at any time.
- `frame_done` output 1: one-cycle pulse when a frame completes.

## Operation
- Storage:
  - `active` frame register, 16 bits, is what is being displayed.
  - `pending` register, 16 bits, with a `pend_v` flag.
  - Digit index `idx`, 2 bits.
  - Cycle counter, width `$clog2(max(DIGIT_CYCLES,BLANK_CYCLES)+1)`.
- Handshake:
  - `wr_ready = ~pend_v`.
  - A write is accepted when `wr_valid & wr_ready`. It loads `pending` and sets `pend_v`.
  - `wr_data` is ignored when `wr_ready` is low.
- States:
  - IDLE:
    - `anodes=4'b1111`, `idx=0`.
    - If `pend_v` is set, `pending` is copied to `active` and `pend_v` clears the next cycle.
    - Goes to LIGHT when `enable=1`.
  - LIGHT:
    - `anodes = ~(4'b0001 << idx)`, `code = active[4*idx +: 4]`.
    - After `DIGIT_CYCLES` cycles, goes to BLANK (macro defined) or to LIGHT for `idx+1` (macro undefined).
  - BLANK:
    - `anodes=4'b1111`, `code` holds its last value.
    - After `BLANK_CYCLES` cycles, goes to LIGHT for `idx+1`.
- Frame boundary: the last cycle of digit 3's period, i.e. its LIGHT period, or its BLANK period when the macro is defined. On that cycle:
  - `idx` wraps from 3 to 0.
  - `frame_done` pulses.
  - If `pend_v` is set, `pending` is copied to `active` and `pend_v` clears.
- `enable` low in any state: go to IDLE the next cycle with `anodes=4'b1111` and `idx=0`. `pending`/`pend_v` and `active` are retained. No `frame_done` pulse.
- Simultaneous events:
  - Write accepted on a boundary cycle while `pend_v=0`: the frame lands in `pending` and is promoted at the next boundary, not this one.
  - Boundary while `pend_v=1`: `pend_v` clears, and `wr_ready` rises the following cycle.
- Reset mid-operation: all state returns to reset values immediately. Any pending frame is discarded.

## Timing
- Reset values:
  - `anodes=4'b1111`, `code=4'h0`, `frame_done=0`, `wr_ready=1`.
  - `active=16'h0000`, `pend_v=0`, state IDLE.
- All outputs are registered except `wr_ready`, which is a direct inverse of the `pend_v` flop.
- Start-up: `enable` rising, sampled at edge t, gives digit 0 lit from edge t+1.
- Digit period:
  - `DIGIT_CYCLES` (macro undefined).
  - `DIGIT_CYCLES+BLANK_CYCLES` (macro defined).
- Frame period is 4× the digit period, and `frame_done` fires once per frame.
- Write-to-display latency is at most one frame plus one cycle. In IDLE it is 2 cycles from acceptance to `active` updated.

## Configuration
- `DISP_BLANK_EN` defined:
  - The BLANK state is compiled in, and an all-off gap of `BLANK_CYCLES` follows each digit to suppress ghosting.
  - The frame boundary is the end of digit 3's blank period.
- `DISP_BLANK_EN` undefined:
  - There is no BLANK state, and digits switch back-to-back.
  - The `BLANK_CYCLES` parameter is unused.

## Test plan
All scenarios use `DIGIT_CYCLES=4` and `BLANK_CYCLES=2`.
- Reset then idle: `rst_n` low, then high with `enable=0` -> `anodes=1111`, `code=0`, `wr_ready=1` for all cycles.
- IDLE load: write `16'h4321` with `enable=0`, then `enable=1` -> `anodes` sequence 1110/1101/1011/0111 with `code` 1/2/3/4, each held 4 cycles; with the macro, each digit is followed by 2 cycles of 1111.
- Tear-free swap: while scanning `16'h4321`, write `16'h8765` mid-frame -> `wr_ready` low until the boundary; the current frame finishes as 1,2,3,4; the next frame shows 5,6,7,8; `frame_done` pulses once per frame.
- Back-pressure: while `pend_v=1`, hold `wr_valid` with `16'hAAAA` -> the write is not accepted; it is accepted the cycle after the boundary.
- Boundary collision: with `pend_v=0`, write `16'h9999` on the boundary cycle -> the frame after the boundary still shows the old contents; `9999` appears one frame later.
- Abort: drop `enable` during digit 2 -> `anodes=1111` the next cycle; re-enable -> restart at digit 0 with the same `active` frame; assert `rst_n` low mid-frame -> all outputs at reset values immediately.
